// File: rtl/layer_norm_stats.sv
// Row statistics for LayerNorm: accumulates one row, then produces the rounded mean and
// 1/sqrt(var + eps) using a bit-serial restoring square root followed by a restoring divide.
module layer_norm_stats #(
   parameter int unsigned X_WIDTH       = 16,
   parameter int unsigned X_FRAC        = 10,
   parameter int unsigned LOG2_N        = 6,
   parameter int unsigned MU_WIDTH      = 24,
   parameter int unsigned INV_STD_WIDTH = 24,
   parameter int unsigned INV_STD_FRAC  = 14,
   parameter int unsigned EPS           = 11
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            x_valid,
   input  logic signed [X_WIDTH-1:0]       x_in,
   output logic                            x_ready,
   output logic                            stats_valid,
   output logic signed [MU_WIDTH-1:0]      mu_out,
   output logic signed [INV_STD_WIDTH-1:0] inv_std_out,
   output logic                            busy
);

   localparam int unsigned SUM_W  = X_WIDTH + LOG2_N;
   localparam int unsigned SQ_W   = 2 * X_WIDTH + LOG2_N;
   localparam int unsigned RAD_W  = 2 * X_WIDTH;
   localparam int unsigned REM_W  = X_WIDTH + 3;
   localparam int unsigned DIV_W  = INV_STD_FRAC + X_FRAC + 1;
   localparam int unsigned DREM_W = X_WIDTH + 1;
   localparam int unsigned ITER_W = $clog2(DIV_W);
   localparam int unsigned RND    = 1 << (LOG2_N - 1);

   localparam logic [DIV_W-1:0]  DIV_TOP   = {1'b1, {(DIV_W-1){1'b0}}};
   localparam logic [DIV_W-1:0]  INV_MAX   = DIV_W'({(INV_STD_WIDTH-1){1'b1}});
   localparam logic [ITER_W-1:0] SQRT_LAST = ITER_W'(X_WIDTH - 1);
   localparam logic [ITER_W-1:0] DIV_LAST  = ITER_W'(DIV_W - 1);

   typedef enum logic [1:0] {StAccum, StMean, StSqrt, StDiv} state_e;

   state_e                    state_q, state_d;
   logic signed [SUM_W-1:0]   sum_q;
   logic [SQ_W-1:0]           sumsq_q;
   logic [LOG2_N-1:0]         cnt_q;
   logic [ITER_W-1:0]         iter_q;
   logic signed [X_WIDTH-1:0] mu_q;
   logic [RAD_W-1:0]          rad_q;
   logic [REM_W-1:0]          rem_q;
   logic [X_WIDTH-1:0]        root_q;
   logic [DREM_W-1:0]         drem_q;
   logic [DIV_W-1:0]          dnum_q;
   logic [DIV_W-1:0]          quo_q;

   logic                        xfer;
   logic signed [2*X_WIDTH-1:0] x_sq;
   logic signed [SUM_W-1:0]     sum_rnd;
   logic signed [X_WIDTH-1:0]   mean;
   logic signed [2*X_WIDTH-1:0] mean_sq;
   logic [RAD_W-1:0]            msq;
   logic signed [RAD_W:0]       diff;
   logic [RAD_W-1:0]            var_c;
   logic [RAD_W-1:0]            rad;
   logic [REM_W-1:0]            rem_sh, trial, rem_nxt;
   logic                        sq_ge;
   logic [X_WIDTH-1:0]          root_nxt;
   logic [DREM_W-1:0]           drem_sh, divisor, drem_nxt;
   logic                        dv_ge;
   logic [DIV_W-1:0]            quo_nxt, inv_sat;

   assign xfer = x_valid & x_ready;
   assign x_sq = x_in * x_in;

   // Mean with round-half-up, then var = E[x^2] - mu^2 in Q.20, clamped at zero.
   assign sum_rnd = sum_q + SUM_W'(RND);
   assign mean    = X_WIDTH'(sum_rnd >>> LOG2_N);
   assign mean_sq = mean * mean;
   assign msq     = RAD_W'(sumsq_q >> LOG2_N);
   assign diff    = $signed({1'b0, msq}) - $signed({1'b0, $unsigned(mean_sq)});
   assign var_c   = diff[RAD_W] ? '0 : diff[RAD_W-1:0];
   assign rad     = var_c + RAD_W'(EPS);

   // One root bit per cycle: bring down two radicand bits, try subtracting 4r+1.
   assign rem_sh   = REM_W'({rem_q, rad_q[RAD_W-1 -: 2]});
   assign trial    = REM_W'({root_q, 2'b01});
   assign sq_ge    = rem_sh >= trial;
   assign rem_nxt  = sq_ge ? rem_sh - trial : rem_sh;
   assign root_nxt = X_WIDTH'({root_q, sq_ge});

   assign drem_sh  = DREM_W'({drem_q, dnum_q[DIV_W-1]});
   assign divisor  = {1'b0, root_q};
   assign dv_ge    = drem_sh >= divisor;
   assign drem_nxt = dv_ge ? drem_sh - divisor : drem_sh;
   assign quo_nxt  = DIV_W'({quo_q, dv_ge});
   assign inv_sat  = (root_q == '0 || quo_nxt > INV_MAX) ? INV_MAX : quo_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StAccum;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StAccum;
      end else begin
         unique case (state_q)
            StAccum: if (xfer && cnt_q == {LOG2_N{1'b1}}) state_d = StMean;
            StMean:  state_d = StSqrt;
            StSqrt:  if (iter_q == SQRT_LAST) state_d = StDiv;
            StDiv:   if (iter_q == DIV_LAST) state_d = StAccum;
            default: state_d = StAccum;
         endcase
      end
   end

   always_comb begin
      x_ready = 1'b0;
      busy    = 1'b0;
      if (state_q == StAccum) x_ready = 1'b1;
      else                    busy    = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         sumsq_q     <= '0;
         cnt_q       <= '0;
         iter_q      <= '0;
         mu_q        <= '0;
         rad_q       <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         drem_q      <= '0;
         dnum_q      <= '0;
         quo_q       <= '0;
         stats_valid <= 1'b0;
         mu_out      <= '0;
         inv_std_out <= '0;
      end else begin
         stats_valid <= 1'b0;
         if (flush) begin
            sum_q   <= '0;
            sumsq_q <= '0;
            cnt_q   <= '0;
            iter_q  <= '0;
         end else begin
            unique case (state_q)
               StAccum: begin
                  if (xfer) begin
                     sum_q   <= sum_q + {{LOG2_N{x_in[X_WIDTH-1]}}, x_in};
                     sumsq_q <= sumsq_q + SQ_W'($unsigned(x_sq));
                     cnt_q   <= cnt_q + 1'b1;
                  end
               end
               StMean: begin
                  mu_q    <= mean;
                  rad_q   <= rad;
                  rem_q   <= '0;
                  root_q  <= '0;
                  iter_q  <= '0;
                  sum_q   <= '0;
                  sumsq_q <= '0;
                  cnt_q   <= '0;
               end
               StSqrt: begin
                  rad_q  <= rad_q << 2;
                  rem_q  <= rem_nxt;
                  root_q <= root_nxt;
                  if (iter_q == SQRT_LAST) begin
                     iter_q <= '0;
                     drem_q <= '0;
                     dnum_q <= DIV_TOP;
                     quo_q  <= '0;
                  end else begin
                     iter_q <= iter_q + 1'b1;
                  end
               end
               StDiv: begin
                  dnum_q <= dnum_q << 1;
                  drem_q <= drem_nxt;
                  quo_q  <= quo_nxt;
                  if (iter_q == DIV_LAST) begin
                     iter_q      <= '0;
                     mu_out      <= {{(MU_WIDTH-X_WIDTH){mu_q[X_WIDTH-1]}}, mu_q};
                     inv_std_out <= INV_STD_WIDTH'(inv_sat);
                     stats_valid <= 1'b1;
                  end else begin
                     iter_q <= iter_q + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/layer_norm_stats.md
# layer_norm_stats

Streaming statistics unit that sits directly upstream of the per-element LayerNorm PE array. It accepts one row of `2**LOG2_N` activations (S5.10), accumulates sum and sum-of-squares, then computes the row mean `mu` (S13.10) and `inv_std = 1/sqrt(var + eps)` (S9.14). It uses a multi-cycle restoring square root and restoring divider. The results drive the PEs' `mu_common_in` / `inv_std_eff_common_in` buses, held stable until the next row completes.

## Interface
- `X_WIDTH`, 16, input element width (signed)
- `X_FRAC`, 10, input fractional bits
- `LOG2_N`, 6, log2 of row length N (N = 64)
- `MU_WIDTH`, 24, mean output width; `MU_FRAC` = X_FRAC fixed
- `INV_STD_WIDTH`, 24, inv_std output width
- `INV_STD_FRAC`, 14, inv_std fractional bits
- `EPS`, 11, epsilon added to variance, unsigned integer in Q.(2·X_FRAC) units (11·2^-20 ≈ 1.05e-5)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous abort: discard partial row/computation, return to ACCUM
- `x_valid`  in  1  input element valid
- `x_in`  in  X_WIDTH  signed S5.10 element
- `x_ready`  out  1  block accepts element (high only in ACCUM)
- `stats_valid`  out  1  one-cycle pulse: `mu_out`/`inv_std_out` updated this cycle
- `mu_out`  out  MU_WIDTH  signed S13.10 row mean, held
- `inv_std_out`  out  INV_STD_WIDTH  signed S9.14 inverse std-dev (always ≥ 0), held
- `busy`  out  1  high in MEAN/SQRT/DIV

## Operation
- FSM: ACCUM → MEAN → SQRT → DIV → ACCUM.
- ACCUM: `x_ready`=1. Transfer on `x_valid & x_ready`. `sum += x` (X_WIDTH+LOG2_N bits, signed); `sumsq += x*x` (2·X_WIDTH+LOG2_N bits, unsigned, Q.20); element counter increments. On the transfer of element N-1 → MEAN.
- MEAN (1 cycle):
  - `mu = (sum + 2^(LOG2_N-1)) >>> LOG2_N` (round half up), sign-extended to MU_WIDTH.
  - `var = (sumsq >> LOG2_N) - mu*mu` (floor, Q.20). Clamp to 0 if negative. `rad = var + EPS` (32-bit unsigned).
  - Clear `sum`, `sumsq`, counter → SQRT.
- SQRT: restoring integer square root, one result bit per cycle, X_WIDTH cycles. `root = floor(sqrt(rad))`, Q.10 unsigned → DIV.
- DIV: restoring divide `q = floor(2^(INV_STD_FRAC+X_FRAC) / root)`, one quotient bit per cycle, INV_STD_FRAC+X_FRAC+1 cycles (25).
  - Saturate to 2^(INV_STD_WIDTH-1)-1 if q exceeds it or `root` = 0.
  - Register `mu_out`, `inv_std_out`; pulse `stats_valid`; → ACCUM.
- `mu_out`/`inv_std_out` change only in the `stats_valid` cycle.
- `x_valid` while `x_ready`=0 is ignored (no buffering).
- `flush`: from any state, next edge → ACCUM; accumulators and counter cleared; no `stats_valid`; outputs keep previous values. `flush` has priority over a simultaneous transfer (that element is dropped).

## Timing
- Reset: FSM=ACCUM, accumulators/counter=0; `x_ready`=1, `stats_valid`=0, `busy`=0, `mu_out`=0, `inv_std_out`=0.
- Throughput in ACCUM: 1 element/cycle.
- Latency: with E0 the edge accepting the last element, `stats_valid`=1 after edge E0+42 (1 MEAN + 16 SQRT + 25 DIV). General formula: 1 + X_WIDTH + INV_STD_FRAC + X_FRAC + 1.
- `busy`=1 and `x_ready`=0 from after E0 through E0+41. After E0+42: `x_ready`=1 in the same cycle `stats_valid` pulses. The first element of the next row may transfer on edge E0+43.
- Reset asserted mid-row or mid-computation: immediate return to reset values. No `stats_valid` is produced for the interrupted row.

## Test plan
- 64× x=1024 (1.0) → `stats_valid` 42 cycles after last accept; `mu_out`=1024; var=0, rad=11, root=3, `inv_std_out`=5592405.
- 64× alternating +1024/−1024 → `mu_out`=0, root=1024, `inv_std_out`=16384 (1.0). Alternating ±2048 → `inv_std_out`=8192.
- Rounding: one x=32, 63× 0 → `mu_out`=1. One x=−32, rest 0 → `mu_out`=0. One x=−33 → `mu_out`=−1 (0xFFFFFF).
- EPS=0, all x=512 → root=0 → `inv_std_out`=8388607. Also 64× x=−32768 → `mu_out`=−32768 sign-extended.
- Backpressure: `x_valid` held high continuously across two rows → exactly 64 transfers per row, none during `busy`. Second row's stats correct and independent of the first.
- `flush` at element 30 and again mid-SQRT; async `rst_n` mid-DIV → no `stats_valid`, outputs unchanged (flush) or zero (reset). The following clean row produces correct results.
